qed_dup_buffer: RTL and testbench

- Sits directly downstream of the RV32M instruction constraint stage, between the constrained symbolic instruction input and the core's fetch interface.
- In original mode it forwards each constrained instruction to the core and enqueues a register-remapped duplicate of it.
- In duplicate mode it replays the queued duplicates in program order.
- It tracks original and duplicate counts so the QED consistency check fires only when both halves have issued.

---
 rtl/qed_dup_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_qed_dup_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_buffer.sv
// rtl/qed_dup_buffer.sv - QED original/duplicate instruction buffer in front of core fetch
//
// Purpose:
//   Original mode (exec_dup=0) forwards each constrained instruction to the
//   core and queues a register-remapped duplicate of it. Duplicate mode
//   (exec_dup=1) replays the queued duplicates in program order. Issued
//   originals and duplicates are counted so the consistency check can be
//   armed only once both halves have issued and nothing is left in flight.
//
// Configuration macro:
//   QED_MEM_REMAP_EN - when defined, duplicate LW/SW also set immediate bit 5
//                      (instruction[25]) so duplicate memory traffic lands in
//                      the upper half of the data window.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena               fetch accepts this cycle; 0 freezes all state/outputs
//   exec_dup          mode select, sampled every cycle
//   ifu_instruction   constrained original instruction
//   ifu_vld           ifu_instruction valid
//   qed_instruction   instruction to core fetch (registered)
//   qed_vld           qed_instruction valid
//   qed_is_dup        current output is a duplicate
//   qed_stall         FIFO full, presented original was not accepted
//   fifo_level        occupied duplicate entries
//   qed_check_ready   originals == duplicates issued, nonzero, FIFO empty

module qed_dup_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          exec_dup,
    input  logic [31:0]   ifu_instruction,
    input  logic          ifu_vld,
    output logic [31:0]   qed_instruction,
    output logic          qed_vld,
    output logic          qed_is_dup,
    output logic          qed_stall,
    output logic [AW:0]   fifo_level,
    output logic          qed_check_ready
);

    localparam logic [31:0] NOP       = 32'h0000_007F;
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    // Register fields of originals are always below x16, so setting bit 4 of
    // each used field moves the duplicate into the disjoint x16..x31 bank.
    function automatic logic [31:0] dup_remap(input logic [31:0] ins);
        logic [31:0] r;
        r = ins;
        case (ins[6:0])
            OP_R: begin
                r[11] = 1'b1;   // rd
                r[19] = 1'b1;   // rs1
                r[24] = 1'b1;   // rs2
            end
            OP_I: begin
                r[11] = 1'b1;
                r[19] = 1'b1;
            end
            OP_LW: begin
                r[11] = 1'b1;   // rs1 stays x0 as the common base
`ifdef QED_MEM_REMAP_EN
                r[25] = 1'b1;   // imm bit 5: +32 byte offset
`endif
            end
            OP_SW: begin
                r[19] = 1'b1;   // rs2 stays x0
`ifdef QED_MEM_REMAP_EN
                r[25] = 1'b1;   // imm[11:5] bit 0 == imm bit 5
`endif
            end
            default: r = ins;
        endcase
        return r;
    endfunction

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [CW-1:0] orig_cnt_q, orig_cnt_d;
    logic [CW-1:0] dup_cnt_q, dup_cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic          vld_q, vld_d;
    logic          is_dup_q, is_dup_d;
    logic          stall_q, stall_d;
    logic          check_ready_q, check_ready_d;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [31:0]   dup_instr;

    assign full      = (level_q == DEPTH_LVL);
    assign empty     = (level_q == '0);
    assign dup_instr = dup_remap(ifu_instruction);

    always_comb begin
        push          = 1'b0;
        pop           = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        orig_cnt_d    = orig_cnt_q;
        dup_cnt_d     = dup_cnt_q;
        instr_d       = instr_q;
        vld_d         = vld_q;
        is_dup_d      = is_dup_q;
        stall_d       = stall_q;
        check_ready_d = check_ready_q;

        if (ena) begin
            instr_d  = NOP;
            vld_d    = 1'b0;
            is_dup_d = 1'b0;
            stall_d  = 1'b0;

            if (!exec_dup) begin
                if (ifu_vld) begin
                    if (full) begin
                        // Source must hold and re-present this instruction.
                        stall_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        instr_d = ifu_instruction;
                        vld_d   = 1'b1;
                    end
                end
            end else if (!empty) begin
                pop      = 1'b1;
                instr_d  = mem_q[rd_ptr_q];
                vld_d    = 1'b1;
                is_dup_d = 1'b1;
            end

            // Push and pop never coincide: the mode selects exactly one.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                level_d  = level_q + 1'b1;
                if (orig_cnt_q != '1) orig_cnt_d = orig_cnt_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                level_d  = level_q - 1'b1;
                if (dup_cnt_q != '1) dup_cnt_d = dup_cnt_q + 1'b1;
            end

            // Evaluated on next-state values so the flag rises together with
            // the output of the final duplicate.
            check_ready_d = (orig_cnt_d == dup_cnt_d) && (orig_cnt_d != '0)
                            && (level_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            orig_cnt_q    <= '0;
            dup_cnt_q     <= '0;
            instr_q       <= NOP;
            vld_q         <= 1'b0;
            is_dup_q      <= 1'b0;
            stall_q       <= 1'b0;
            check_ready_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            orig_cnt_q    <= orig_cnt_d;
            dup_cnt_q     <= dup_cnt_d;
            instr_q       <= instr_d;
            vld_q         <= vld_d;
            is_dup_q      <= is_dup_d;
            stall_q       <= stall_d;
            check_ready_q <= check_ready_d;
        end
    end

    // Storage needs no reset: clearing the pointers/level discards contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dup_instr;
    end

    assign qed_instruction = instr_q;
    assign qed_vld         = vld_q;
    assign qed_is_dup      = is_dup_q;
    assign qed_stall       = stall_q;
    assign fifo_level      = level_q;
    assign qed_check_ready = check_ready_q;

endmodule

// File: tb/tb_qed_dup_buffer.sv
// tb/tb_qed_dup_buffer.sv - directed self-checking bench for qed_dup_buffer

module tb_qed_dup_buffer;

    localparam logic [31:0] NOP = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        exec_dup;
    logic [31:0] ifu_instruction;
    logic        ifu_vld;
    logic [31:0] qed_instruction;
    logic        qed_vld;
    logic        qed_is_dup;
    logic        qed_stall;
    logic [4:0]  fifo_level;
    logic        qed_check_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qed_dup_buffer #(.DEPTH(16), .AW(4), .CW(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .ena             (ena),
        .exec_dup        (exec_dup),
        .ifu_instruction (ifu_instruction),
        .ifu_vld         (ifu_vld),
        .qed_instruction (qed_instruction),
        .qed_vld         (qed_vld),
        .qed_is_dup      (qed_is_dup),
        .qed_stall       (qed_stall),
        .fifo_level      (fifo_level),
        .qed_check_ready (qed_check_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ena = 1'b1; exec_dup = 1'b0; ifu_vld = 1'b0; ifu_instruction = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_orig(input logic [31:0] ins);
        exec_dup = 1'b0; ifu_vld = 1'b1; ifu_instruction = ins;
        step();
        ifu_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; exec_dup = 1'b0; ifu_vld = 1'b0; ifu_instruction = '0;
        #3;
        checks++; if (qed_instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", qed_instruction, NOP); end
        checks++; if (qed_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", qed_vld); end
        checks++; if (qed_is_dup !== 1'b0) begin errors++; $display("FAIL reset_is_dup got %b exp 0", qed_is_dup); end
        checks++; if (qed_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", qed_stall); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (qed_check_ready !== 1'b0) begin errors++; $display("FAIL reset_check_ready got %b exp 0", qed_check_ready); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_add_dup();
        do_reset();
        push_orig(32'h003100B3);
        checks++; if (qed_instruction !== 32'h003100B3) begin errors++; $display("FAIL add_orig_instr got %h exp 003100b3", qed_instruction); end
        checks++; if (qed_vld !== 1'b1 || qed_is_dup !== 1'b0) begin errors++; $display("FAIL add_orig_flags got vld=%b dup=%b exp vld=1 dup=0", qed_vld, qed_is_dup); end
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL add_orig_level got %0d exp 1", fifo_level); end
        checks++; if (qed_check_ready !== 1'b0) begin errors++; $display("FAIL add_orig_ready got %b exp 0", qed_check_ready); end
        exec_dup = 1'b1;
        step();
        checks++; if (qed_instruction !== 32'h013908B3) begin errors++; $display("FAIL add_dup_instr got %h exp 013908b3", qed_instruction); end
        checks++; if (qed_vld !== 1'b1 || qed_is_dup !== 1'b1) begin errors++; $display("FAIL add_dup_flags got vld=%b dup=%b exp 1 1", qed_vld, qed_is_dup); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL add_dup_level got %0d exp 0", fifo_level); end
        checks++; if (qed_check_ready !== 1'b1) begin errors++; $display("FAIL add_dup_ready got %b exp 1", qed_check_ready); end
    endtask

    task automatic test_dup_empty();
        do_reset();
        exec_dup = 1'b1; ifu_vld = 1'b1; ifu_instruction = 32'h003100B3;
        step();
        checks++; if (qed_instruction !== NOP) begin errors++; $display("FAIL empty_instr got %h exp %h", qed_instruction, NOP); end
        checks++; if (qed_vld !== 1'b0) begin errors++; $display("FAIL empty_vld got %b exp 0", qed_vld); end
        checks++; if (qed_check_ready !== 1'b0) begin errors++; $display("FAIL empty_ready got %b exp 0", qed_check_ready); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL empty_level got %0d exp 0", fifo_level); end
        // A spurious duplicate count would keep the counts unequal here.
        push_orig(32'h003100B3);
        exec_dup = 1'b1;
        step();
        checks++; if (qed_check_ready !== 1'b1) begin errors++; $display("FAIL empty_then_pair_ready got %b exp 1", qed_check_ready); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 16; i++) push_orig((32'(i) << 12) | 32'h37);
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", fifo_level); end
        push_orig((32'd17 << 12) | 32'h37);
        checks++; if (qed_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", qed_stall); end
        checks++; if (qed_vld !== 1'b0 || qed_instruction !== NOP) begin errors++; $display("FAIL full_out got vld=%b instr=%h exp vld=0 instr=%h", qed_vld, qed_instruction, NOP); end
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level_hold got %0d exp 16", fifo_level); end
        exec_dup = 1'b1;
        step();
        checks++; if (qed_instruction !== 32'h00001037 || qed_stall !== 1'b0 || fifo_level !== 5'd15) begin errors++; $display("FAIL full_pop got instr=%h stall=%b lvl=%0d exp 00001037 0 15", qed_instruction, qed_stall, fifo_level); end
        push_orig((32'd17 << 12) | 32'h37);
        checks++; if (qed_vld !== 1'b1 || qed_instruction !== 32'h00011037 || fifo_level !== 5'd16) begin errors++; $display("FAIL full_represent got vld=%b instr=%h lvl=%0d exp 1 00011037 16", qed_vld, qed_instruction, fifo_level); end
        exec_dup = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            step();
            checks++;
            if (qed_instruction !== ((32'(i) << 12) | 32'h37) || qed_is_dup !== 1'b1) begin
                errors++; $display("FAIL full_drain_%0d got %h dup=%b exp %h dup=1", i, qed_instruction, qed_is_dup, (32'(i) << 12) | 32'h37);
            end
        end
        checks++; if (qed_check_ready !== 1'b1 || fifo_level !== 5'd0) begin errors++; $display("FAIL full_drain_end got ready=%b lvl=%0d exp 1 0", qed_check_ready, fifo_level); end
    endtask

    task automatic test_remap();
        logic [31:0] exp_lw;
        logic [31:0] exp_sw;
`ifdef QED_MEM_REMAP_EN
        exp_lw = 32'h02402A83;
        exp_sw = 32'h020BA423;
`else
        exp_lw = 32'h00402A83;
        exp_sw = 32'h000BA423;
`endif
        do_reset();
        push_orig(32'h00402283);
        checks++; if (qed_instruction !== 32'h00402283) begin errors++; $display("FAIL lw_orig got %h exp 00402283", qed_instruction); end
        push_orig(32'h0003A423);
        push_orig(32'h00520193);
        exec_dup = 1'b1;
        step();
        checks++; if (qed_instruction !== exp_lw) begin errors++; $display("FAIL lw_dup got %h exp %h", qed_instruction, exp_lw); end
        step();
        checks++; if (qed_instruction !== exp_sw) begin errors++; $display("FAIL sw_dup got %h exp %h", qed_instruction, exp_sw); end
        step();
        checks++; if (qed_instruction !== 32'h005A0993) begin errors++; $display("FAIL addi_dup got %h exp 005a0993", qed_instruction); end
    endtask

    task automatic test_ena_freeze();
        do_reset();
        push_orig(32'h00001037);
        push_orig(32'h00002037);
        push_orig(32'h00003037);
        ena = 1'b0; ifu_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exec_dup = i[0];
            ifu_instruction = 32'h00100093 + 32'(i);
            step();
            checks++;
            if (qed_instruction !== 32'h00003037 || qed_vld !== 1'b1 || qed_is_dup !== 1'b0 || fifo_level !== 5'd3) begin
                errors++; $display("FAIL freeze_%0d got instr=%h vld=%b dup=%b lvl=%0d exp 00003037 1 0 3", i, qed_instruction, qed_vld, qed_is_dup, fifo_level);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (fifo_level !== 5'd0 || qed_instruction !== NOP || qed_vld !== 1'b0) begin errors++; $display("FAIL async_rst got lvl=%0d instr=%h vld=%b exp 0 %h 0", fifo_level, qed_instruction, qed_vld, NOP); end
        step();
        rst = 1'b0; ena = 1'b1; ifu_vld = 1'b0;
        exec_dup = 1'b1;
        step();
        checks++; if (qed_vld !== 1'b0) begin errors++; $display("FAIL rst_discard got vld=%b exp 0", qed_vld); end
    endtask

    task automatic test_interleave();
        do_reset();
        push_orig(32'h003100B3);
        push_orig(32'h02628233);
        exec_dup = 1'b1;
        step();
        checks++; if (qed_instruction !== 32'h013908B3 || qed_check_ready !== 1'b0) begin errors++; $display("FAIL il_dup1 got %h ready=%b exp 013908b3 0", qed_instruction, qed_check_ready); end
        push_orig(32'h000AB037);
        checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL il_level got %0d exp 2", fifo_level); end
        exec_dup = 1'b1;
        step();
        checks++; if (qed_instruction !== 32'h036A8A33 || qed_check_ready !== 1'b0) begin errors++; $display("FAIL il_dup2 got %h ready=%b exp 036a8a33 0", qed_instruction, qed_check_ready); end
        step();
        checks++; if (qed_instruction !== 32'h000AB037 || qed_is_dup !== 1'b1) begin errors++; $display("FAIL il_dup3 got %h dup=%b exp 000ab037 1", qed_instruction, qed_is_dup); end
        checks++; if (qed_check_ready !== 1'b1 || fifo_level !== 5'd0) begin errors++; $display("FAIL il_ready got %b lvl=%0d exp 1 0", qed_check_ready, fifo_level); end
    endtask

    initial begin
        test_reset();
        test_add_dup();
        test_dup_empty();
        test_full();
        test_remap();
        test_ena_freeze();
        test_interleave();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
